// File: rtl/controlador_es.sv
`default_nettype none
// ============================================================================
// Module      : controlador_es
// Description : IN/OUT/HALT sequencer for the single-cycle core. It stalls
//               the PC and masks register writes while an IN instruction
//               waits for the operator's confirm key, or while HALT is active.
//               It also latches OUT values into a display register and
//               debounces the confirm key.
//               Optional macro IO_TIMEOUT_EN adds an IN wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_es #(
    parameter int DATA_WIDTH      = 32,
    parameter int SWITCH_WIDTH    = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    isInsert,
    input  logic                    isHalt,
    input  logic                    outWrite,
    input  logic                    confirmKey,
    input  logic [SWITCH_WIDTH-1:0] switches,
    input  logic [DATA_WIDTH-1:0]   outValue,
    output logic                    stallPC,
    output logic                    regWriteEnable,
    output logic [DATA_WIDTH-1:0]   inData,
    output logic [DATA_WIDTH-1:0]   outData,
    output logic                    outValid,
    output logic                    waitingInput,
    output logic                    halted,
    output logic                    timedOut
);

    localparam logic [2:0] c_ST_RUN       = 3'd0;
    localparam logic [2:0] c_ST_IN_WAIT   = 3'd1;
    localparam logic [2:0] c_ST_IN_COMMIT = 3'd2;
    localparam logic [2:0] c_ST_HALTED    = 3'd3;
    localparam logic [2:0] c_ST_RESUME    = 3'd4;

    localparam int c_DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets that cannot be built meaningfully.
    if (SWITCH_WIDTH > DATA_WIDTH || DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("controlador_es: invalid parameter set");
    end

    logic [2:0]            r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [1:0]            r_sync_vld;
    logic                  r_key_level;
    logic                  r_armed;
    logic [c_DEB_W-1:0]    r_deb_cnt;
    logic                  r_confirm_edge;
    logic [DATA_WIDTH-1:0] r_in_data;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  w_timeout;
    logic                  w_stall;
    logic                  w_reg_we;

    // Synchronise and debounce the confirm key. r_armed stays low until the
    // synchronised key has been seen released, so a key held through reset
    // cannot produce an edge until it is released and pressed again.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1        <= 1'b0;
            r_sync2        <= 1'b0;
            r_sync_vld     <= 2'b00;
            r_key_level    <= 1'b0;
            r_armed        <= 1'b0;
            r_deb_cnt      <= '0;
            r_confirm_edge <= 1'b0;
        end else begin
            r_sync1        <= confirmKey;
            r_sync2        <= r_sync1;
            r_sync_vld     <= {r_sync_vld[0], 1'b1};
            r_confirm_edge <= 1'b0;
            if (r_sync_vld[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end
            if (r_sync2 != r_key_level) begin
                if (r_deb_cnt == c_DEB_LAST) begin
                    r_key_level    <= r_sync2;
                    r_deb_cnt      <= '0;
                    r_confirm_edge <= r_sync2 & r_armed;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

`ifdef IO_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timed_out;

    assign w_timeout = (r_state == c_ST_IN_WAIT) && (r_to_cnt == c_TO_LAST);

    // Count cycles spent in IN_WAIT (zero elsewhere, so each wait starts at 0);
    // the timeout flag is sticky until reset and loses to a same-cycle key.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_to_cnt    <= '0;
            r_timed_out <= 1'b0;
        end else begin
            if (r_state == c_ST_IN_WAIT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
            if (w_timeout && !r_confirm_edge) begin
                r_timed_out <= 1'b1;
            end
        end
    end

    assign timedOut = r_timed_out;
`else
    assign w_timeout = 1'b0;
    assign timedOut  = 1'b0;
`endif

    // Sequencer state plus the registered data outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_RUN;
            r_in_data   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                c_ST_RUN: begin
                    if (isHalt) begin
                        r_state <= c_ST_HALTED;
                    end else if (isInsert) begin
                        r_state <= c_ST_IN_WAIT;
                    end else if (outWrite) begin
                        r_out_data  <= outValue;
                        r_out_valid <= 1'b1;
                    end
                end
                c_ST_IN_WAIT: begin
                    if (r_confirm_edge) begin
                        r_in_data <= DATA_WIDTH'(switches);
                        r_state   <= c_ST_IN_COMMIT;
                    end else if (w_timeout) begin
                        r_in_data <= '0;
                        r_state   <= c_ST_IN_COMMIT;
                    end
                end
                c_ST_IN_COMMIT: r_state <= c_ST_RUN;
                c_ST_HALTED: begin
                    if (r_confirm_edge) begin
                        r_state <= c_ST_RESUME;
                    end
                end
                c_ST_RESUME: r_state <= c_ST_RUN;
                default:     r_state <= c_ST_RUN;
            endcase
        end
    end

    // Stall/enable decode; in RUN it looks at the flags so the stall lands in
    // the same cycle the IN or HALT instruction is decoded.
    always_comb begin
        w_stall  = 1'b0;
        w_reg_we = 1'b1;
        case (r_state)
            c_ST_RUN: begin
                if (isHalt || isInsert) begin
                    w_stall  = 1'b1;
                    w_reg_we = 1'b0;
                end
            end
            c_ST_IN_WAIT, c_ST_HALTED: begin
                w_stall  = 1'b1;
                w_reg_we = 1'b0;
            end
            default: begin
                w_stall  = 1'b0;
                w_reg_we = 1'b1;
            end
        endcase
    end

    assign stallPC        = w_stall;
    assign regWriteEnable = w_reg_we;
    assign inData         = r_in_data;
    assign outData        = r_out_data;
    assign outValid       = r_out_valid;
    assign waitingInput   = (r_state == c_ST_IN_WAIT);
    assign halted         = (r_state == c_ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_controlador_es.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_controlador_es
// Description : Self-checking bench for controlador_es: vector table for the
//               RUN-state decode, scoreboard for OUT, hand sequences for HALT,
//               key bounce, reset with a held key and the IN timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_es;

    localparam int DW  = 32;
    localparam int SW  = 16;
    localparam int DEB = 4;
    localparam int TO  = 8;
`ifdef IO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          isInsert = 1'b0;
    logic          isHalt = 1'b0;
    logic          outWrite = 1'b0;
    logic          confirmKey = 1'b0;
    logic [SW-1:0] switches = '0;
    logic [DW-1:0] outValue = '0;
    logic          stallPC;
    logic          regWriteEnable;
    logic [DW-1:0] inData;
    logic [DW-1:0] outData;
    logic          outValid;
    logic          waitingInput;
    logic          halted;
    logic          timedOut;

    always #5 clock = ~clock;

    controlador_es #(
        .DATA_WIDTH(DW), .SWITCH_WIDTH(SW), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .isInsert(isInsert), .isHalt(isHalt),
        .outWrite(outWrite), .confirmKey(confirmKey), .switches(switches),
        .outValue(outValue), .stallPC(stallPC), .regWriteEnable(regWriteEnable),
        .inData(inData), .outData(outData), .outValid(outValid),
        .waitingInput(waitingInput), .halted(halted), .timedOut(timedOut)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] exp_in = '0;

    typedef struct {
        logic          ins;
        logic          hlt;
        logic          ow;
        logic [DW-1:0] val;
        logic [SW-1:0] sw;
        logic          exp_stall;
        logic          exp_wait;
        logic          exp_halt;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // OUT scoreboard: every outValid pulse must match the oldest queued value.
    always @(negedge clock) begin : mon_out
        logic [DW-1:0] e;
        if (reset && outValid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got outValid=1 outData=%h expected no pulse", outData);
            end else begin
                e = sb_q.pop_front();
                chk("out_data", outData, e);
            end
        end
    end

    // Press the key cleanly, wait (bounded) for IN_WAIT/HALTED to exit, check
    // the one-cycle commit/resume, then check RUN and let the key settle low.
    task automatic press_exit(input logic is_in, input logic [DW-1:0] exp_data);
        int n;
        n = 0;
        @(posedge clock); #1 confirmKey = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while ((waitingInput || halted) && n < 60);
        // key -> confirmEdge is DEB+2 cycles, +1 for the state change,
        // +1 because the first sample precedes the first key-sampling edge.
        chk("press_latency", n, DEB + 4);
        chk("commit_stall", stallPC, 1'b0);
        chk("commit_rwe", regWriteEnable, 1'b1);
        if (is_in) chk("commit_indata", inData, exp_data);
        @(posedge clock); #1 isInsert = 1'b0; isHalt = 1'b0;
        @(negedge clock);
        chk("back_run_wait", waitingInput | halted, 1'b0);
        chk("back_run_stall", stallPC, 1'b0);
        confirmKey = 1'b0;
        repeat (DEB + 8) @(posedge clock);
    endtask

    initial begin
        tbl[0] = '{ins:0, hlt:0, ow:1, val:32'hDEADBEEF, sw:16'h0000, exp_stall:0, exp_wait:0, exp_halt:0};
        tbl[1] = '{ins:0, hlt:0, ow:0, val:32'h11111111, sw:16'h0000, exp_stall:0, exp_wait:0, exp_halt:0};
        tbl[2] = '{ins:1, hlt:0, ow:0, val:32'h0,        sw:16'hA5C3, exp_stall:1, exp_wait:1, exp_halt:0};
        tbl[3] = '{ins:0, hlt:0, ow:1, val:32'h12345678, sw:16'h0000, exp_stall:0, exp_wait:0, exp_halt:0};
        tbl[4] = '{ins:0, hlt:1, ow:0, val:32'h0,        sw:16'h0000, exp_stall:1, exp_wait:0, exp_halt:1};
        tbl[5] = '{ins:1, hlt:1, ow:0, val:32'h0,        sw:16'h5555, exp_stall:1, exp_wait:0, exp_halt:1};
        tbl[6] = '{ins:0, hlt:0, ow:1, val:32'h00000000, sw:16'h0000, exp_stall:0, exp_wait:0, exp_halt:0};
        tbl[7] = '{ins:1, hlt:0, ow:0, val:32'h0,        sw:16'hFFFF, exp_stall:1, exp_wait:1, exp_halt:0};
        tbl[8] = '{ins:1, hlt:0, ow:1, val:32'hCAFEF00D, sw:16'h0F0F, exp_stall:1, exp_wait:1, exp_halt:0};

        // Reset state.
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_stall", stallPC, 1'b0);
        chk("rst_rwe", regWriteEnable, 1'b1);
        chk("rst_indata", inData, '0);
        chk("rst_outdata", outData, '0);
        chk("rst_outvalid", outValid, 1'b0);
        chk("rst_flags", {waitingInput, halted, timedOut}, '0);
        @(posedge clock); #1 reset = 1'b1;
        repeat (4) @(posedge clock);

        // Table of decoded instructions in RUN.
        for (int i = 0; i < 9; i++) begin
            @(posedge clock); #1;
            isInsert = tbl[i].ins; isHalt = tbl[i].hlt; outWrite = tbl[i].ow;
            outValue = tbl[i].val; switches = tbl[i].sw;
            if (tbl[i].ow && !tbl[i].ins && !tbl[i].hlt) sb_q.push_back(tbl[i].val);
            @(negedge clock);
            chk("vec_stall", stallPC, tbl[i].exp_stall);
            chk("vec_rwe", regWriteEnable, !tbl[i].exp_stall);
            @(posedge clock); #1;
            outWrite = 1'b0;
            if (!tbl[i].exp_wait && !tbl[i].exp_halt) begin
                isInsert = 1'b0; isHalt = 1'b0;
            end
            @(negedge clock);
            chk("vec_wait", waitingInput, tbl[i].exp_wait);
            chk("vec_halt", halted, tbl[i].exp_halt);
            if (tbl[i].exp_wait || tbl[i].exp_halt) begin
                press_exit(tbl[i].exp_wait, {16'h0000, tbl[i].sw});
                if (tbl[i].exp_wait) exp_in = {16'h0000, tbl[i].sw};
            end
            chk("vec_in_hold", inData, exp_in);
        end
        chk("out_hold", outData, 32'h00000000);

        // Key bounce: toggling every 2 cycles never satisfies the debounce.
        @(posedge clock); #1 switches = 16'h1234;
        if (TO_EN) isHalt = 1'b1; else isInsert = 1'b1;
        @(posedge clock); #1 isHalt = 1'b0; isInsert = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 0) confirmKey = ~confirmKey;
            @(negedge clock);
            chk("bounce_stuck", TO_EN ? halted : waitingInput, 1'b1);
            @(posedge clock); #1;
        end
        confirmKey = 1'b0;
        repeat (DEB + 8) @(posedge clock);
        press_exit(!TO_EN, 32'h00001234);
        if (!TO_EN) exp_in = 32'h00001234;

        // Reset asserted mid-IN_WAIT with the key held down through reset.
        @(posedge clock); #1 isInsert = 1'b1;
        @(posedge clock); #1 isInsert = 1'b0;
        @(negedge clock);
        chk("pre_rst_wait", waitingInput, 1'b1);
        #2 confirmKey = 1'b1; reset = 1'b0;
        #1;
        chk("arst_stall", stallPC, 1'b0);
        chk("arst_rwe", regWriteEnable, 1'b1);
        chk("arst_indata", inData, '0);
        chk("arst_outdata", outData, '0);
        chk("arst_flags", {waitingInput, halted, outValid, timedOut}, '0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1; exp_in = '0;
        @(negedge clock);
        chk("post_rst_run", {waitingInput, halted, stallPC}, '0);
        @(posedge clock); #1 isHalt = 1'b1;
        @(posedge clock); #1 isHalt = 1'b0;
        repeat (20) @(negedge clock);
        chk("held_key_no_edge", halted, 1'b1);
        confirmKey = 1'b0;
        repeat (DEB + 8) @(posedge clock);
        @(negedge clock);
        chk("release_no_edge", halted, 1'b1);
        press_exit(1'b0, '0);

        // HALT with isHalt held through RESUME.
        @(posedge clock); #1 isHalt = 1'b1;
        @(negedge clock);
        chk("halt_same_cycle_stall", stallPC, 1'b1);
        @(negedge clock);
        chk("halt_flag", halted, 1'b1);
        press_exit(1'b0, '0);

`ifdef IO_TIMEOUT_EN
        begin : timeout_seq
            int n;
            n = 0;
            @(posedge clock); #1 isInsert = 1'b1; switches = 16'hBEEF;
            do begin
                @(negedge clock);
                n++;
            end while ((n < 3 || waitingInput) && n < 60);
            // One sample before entry edge, TO cycles waiting, one more for the
            // sample after the exit edge.
            chk("to_latency", n, TO + 2);
            chk("to_indata", inData, '0);
            chk("to_flag", timedOut, 1'b1);
            chk("to_commit_stall", stallPC, 1'b0);
            @(posedge clock); #1 isInsert = 1'b0;
            @(negedge clock);
            chk("to_run", {waitingInput, stallPC}, '0);
            chk("to_sticky", timedOut, 1'b1);
        end
`else
        @(posedge clock); #1 isInsert = 1'b1; switches = 16'h0042;
        @(posedge clock); #1 isInsert = 1'b0;
        repeat (40) @(negedge clock);
        chk("no_to_wait", waitingInput, 1'b1);
        chk("no_to_flag", timedOut, 1'b0);
        press_exit(1'b1, 32'h00000042);
`endif

        chk("sb_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/controlador_es.md
Name: controlador_es

Overview:
- Sequential I/O and halt sequencer for the single-cycle core.
- Consumes the decoder flags isInsert, isHalt and outWrite.
- Stalls the PC and masks register writes while an IN instruction waits for the operator's confirm key, or while HALT is active.
- Latches OUT values into a display register and debounces the confirm key internally.

Parameters:
- DATA_WIDTH, 32, width of the datapath word.
- SWITCH_WIDTH, 16, width of the board switch bank; must be ≤ DATA_WIDTH.
- DEBOUNCE_CYCLES, 50000, consecutive stable samples required before the confirm key level is accepted.
- TIMEOUT_CYCLES, 1000000, IN wait limit; used only with IO_TIMEOUT_EN.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state.
- isInsert  in  1  current instruction is IN.
- isHalt  in  1  current instruction is HALT.
- outWrite  in  1  current instruction is OUT.
- confirmKey  in  1  raw, asynchronous, active-high operator key.
- switches  in  SWITCH_WIDTH  raw board switches.
- outValue  in  DATA_WIDTH  ALU result carrying the OUT operand.
- stallPC  out  1  1 = PC holds its value.
- regWriteEnable  out  1  ANDed with the decoder regWrite by the datapath.
- inData  out  DATA_WIDTH  zero-extended latched switches, fed to the register write mux.
- outData  out  DATA_WIDTH  display register.
- outValid  out  1  one-cycle pulse when outData is updated.
- waitingInput  out  1  high in IN_WAIT.
- halted  out  1  high in HALTED.
- timedOut  out  1  sticky timeout flag; constant 0 without IO_TIMEOUT_EN.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN; outputs stallPC=0, regWriteEnable=1, inData=0, outData=0, outValid=0, waitingInput=0, halted=0, timedOut=0.
  - Debounce synchroniser, counter, accepted level and timeout counter all cleared.
- Debounce:
  - confirmKey passes through a 2-FF synchroniser.
  - The counter increments while the synchronised value differs from the accepted level and clears when it matches.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted level takes the synchronised value and the counter clears.
  - confirmEdge is a one-cycle internal pulse on an accepted 0→1 transition.
  - Latency from a clean key press to confirmEdge: DEBOUNCE_CYCLES+2 cycles.
  - A key held across reset produces no edge until it is released and pressed again.
- State machine:
  - States: RUN, IN_WAIT, IN_COMMIT, HALTED, RESUME.
- RUN:
  - stallPC=0, regWriteEnable=1.
  - If isHalt → HALTED. Halt wins if isHalt and isInsert are both set.
  - Else if isInsert → IN_WAIT.
  - Else if outWrite: outData←outValue and outValid=1 next cycle; stay in RUN.
- IN_WAIT:
  - stallPC=1, regWriteEnable=0, waitingInput=1.
  - On confirmEdge: inData←zero-extended switches; → IN_COMMIT.
- IN_COMMIT, exactly one cycle:
  - stallPC=0, regWriteEnable=1, so the register file captures inData.
  - isInsert is ignored in this state; → RUN.
- HALTED:
  - stallPC=1, regWriteEnable=0, halted=1.
  - On confirmEdge → RESUME.
- RESUME, exactly one cycle:
  - stallPC=0, regWriteEnable=1; isHalt is ignored; → RUN.
- State and output timing:
  - Stall and enable outputs are combinational from state.
  - The stall takes effect in the same cycle the flag is decoded, because stallPC is combinational from the next-state condition in RUN.
  - When isInsert or isHalt is seen in RUN, stallPC=1 and regWriteEnable=0 in that cycle.
- confirmEdge is ignored in RUN, IN_COMMIT and RESUME.
- outWrite is honoured only in RUN.
- inData holds its value until the next IN commit.
- outData holds its value until the next OUT.

Optional Feature:
- Macro: IO_TIMEOUT_EN.
- When defined:
  - A counter runs in IN_WAIT and clears on entering it.
  - When it reaches TIMEOUT_CYCLES-1 without confirmEdge: inData←0, timedOut←1 (sticky until reset), → IN_COMMIT.
  - confirmEdge in the same cycle as the limit wins and latches the switches.
- When undefined:
  - No counter is present and timedOut is tied to 0.
  - IN_WAIT waits indefinitely.

Test Plan:
- Reset: assert reset=0 mid-IN_WAIT and release → stallPC=0, regWriteEnable=1, all data outputs 0, state RUN next cycle.
- IN sequence, DEBOUNCE_CYCLES=4: isInsert=1, switches=16'hA5C3, press the key cleanly →
  - stallPC=1 until confirmEdge;
  - then one cycle with stallPC=0, regWriteEnable=1, inData=32'h0000A5C3;
  - then RUN.
- Bounce rejection: confirmKey toggles every 2 cycles for 20 cycles, with DEBOUNCE_CYCLES=4 → no confirmEdge, state stays IN_WAIT.
- OUT: in RUN, outWrite=1, outValue=32'hDEADBEEF → outData=32'hDEADBEEF and outValid=1 for exactly one cycle; stallPC stays 0.
- HALT: isHalt held at 1 → halted=1, stallPC=1; after a key press, RESUME gives one cycle with stallPC=0 while isHalt is still 1, then RUN.
- Timeout (IO_TIMEOUT_EN, TIMEOUT_CYCLES=8): IN with no key press → after 8 cycles, inData=0, timedOut=1, one commit cycle, then RUN.
